prim_rr_onehot_arb: RTL

- Registered round-robin arbiter for N requesters.
- Issues a one-hot grant vector plus the matching binary index under a valid/ready handshake.
- Holds each grant stable until the consumer accepts it.
- Continuously self-checks its own grant state for one-hot, index and enable consistency, and flags any corruption (e.g. fault injection) on err_o.
- Sits in front of shared datapath resources (bus ports, shared buffers) that are steered by a one-hot select plus an address.

---
 rtl/prim_rr_onehot_arb_if.sv | 44 ++++
 rtl/prim_rr_onehot_arb.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/prim_rr_onehot_arb_if.sv
// ---------------------------------------------------------------------------
// prim_rr_onehot_arb_if
//   Handshake bundle between a set of requesters / a grant consumer and the
//   round-robin one-hot arbiter.
//
//   req_i     N     per-requester request level (bit i = requester i)
//   ready_i   1     consumer accepts the presented grant this cycle
//   valid_o   1     a grant is presented
//   gnt_oh_o  N     one-hot grant
//   idx_o     IdxW  binary index of the granted requester
//   err_o     1     grant-state consistency error
//
//   master : the arbiter side (consumes req/ready, drives the grant)
//   slave  : the requester/consumer side
// ---------------------------------------------------------------------------
interface prim_rr_onehot_arb_if #(
    parameter int N    = 8,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]    req_i;
    logic            ready_i;
    logic            valid_o;
    logic [N-1:0]    gnt_oh_o;
    logic [IdxW-1:0] idx_o;
    logic            err_o;

    modport master (
        input  req_i,
        input  ready_i,
        output valid_o,
        output gnt_oh_o,
        output idx_o,
        output err_o
    );

    modport slave (
        output req_i,
        output ready_i,
        input  valid_o,
        input  gnt_oh_o,
        input  idx_o,
        input  err_o
    );
endinterface

// File: rtl/prim_rr_onehot_arb.sv
// ---------------------------------------------------------------------------
// prim_rr_onehot_arb
//   Registered round-robin arbiter for N requesters. Presents a one-hot grant
//   plus its binary index under a valid/ready handshake and holds it until
//   accepted. The presented grant state is continuously checked for one-hot,
//   index and enable consistency; any violation shows on err_o.
//
//   clk_i   in   clock, rising edge
//   rst_i   in   synchronous reset, active-high
//   bus     prim_rr_onehot_arb_if.master
//           req_i, ready_i in; valid_o, gnt_oh_o, idx_o, err_o out
// ---------------------------------------------------------------------------

// Per-requester cell: marks a request as lying at or above the round-robin
// pointer, i.e. in the "first pass" of the wrapped scan.
module prim_rr_onehot_arb_lane #(
    parameter int IdxW = 3,
    parameter int Idx  = 0
) (
    input  logic            req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            hi_req_o
);
    assign hi_req_o = req_i && (IdxW'(Idx) >= ptr_i);
endmodule

module prim_rr_onehot_arb #(
    parameter int N    = 8,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    prim_rr_onehot_arb_if.master  bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [N-1:0]    gnt_q, gnt_d;

    logic            handshake;
    logic [IdxW-1:0] idx_inc;
    logic [IdxW-1:0] arb_ptr;
    logic [N-1:0]    hi_req;
    logic            hi_found, any_req;
    logic [IdxW-1:0] hi_idx, lo_idx, win_idx;
    logic [N-1:0]    win_oh;

    assign handshake = (state_q == GRANT) && bus.ready_i;

    // Successor of the granted index, modulo N (N need not be a power of two).
    assign idx_inc = (32'(idx_q) == 32'(N - 1)) ? '0 : idx_q + IdxW'(1);

    // On a handshake the pointer moves past the accepted grant and the
    // follow-on grant is chosen with that moved pointer in the same cycle.
    assign arb_ptr = handshake ? idx_inc : ptr_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        prim_rr_onehot_arb_lane #(
            .IdxW (IdxW),
            .Idx  (i)
        ) u_lane (
            .req_i    (bus.req_i[i]),
            .ptr_i    (arb_ptr),
            .hi_req_o (hi_req[i])
        );
    end

    // Wrapped scan as two priority passes: lowest request at/above the
    // pointer wins; otherwise the lowest request overall (the wrapped part).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        any_req  = 1'b0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                hi_found = 1'b1;
                hi_idx   = IdxW'(i);
            end
            if (bus.req_i[i]) begin
                any_req = 1'b1;
                lo_idx  = IdxW'(i);
            end
        end
    end

    assign win_idx = hi_found ? hi_idx : lo_idx;

    always_comb begin
        win_oh = '0;
        for (int i = 0; i < N; i++) begin
            win_oh[i] = (win_idx == IdxW'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        // A presented grant is only replaced on acceptance; otherwise it is
        // held regardless of what happens on req_i.
        if ((state_q == IDLE) || handshake) begin
            if (handshake) begin
                ptr_d = idx_inc;
            end
            if (any_req) begin
                state_d = GRANT;
                idx_d   = win_idx;
                gnt_d   = win_oh;
            end else begin
                state_d = IDLE;
                idx_d   = '0;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.valid_o  = (state_q == GRANT);
    assign bus.gnt_oh_o = gnt_q;
    assign bus.idx_o    = idx_q;

    // Consistency checker. It looks at the values actually presented on the
    // bus so that any corruption between the flops and the consumer shows up.
    logic gnt_at_idx;
    logic multi_hot;
    logic idx_oob;

    always_comb begin
        gnt_at_idx = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.idx_o == IdxW'(i)) begin
                gnt_at_idx = bus.gnt_oh_o[i];
            end
        end
    end

    // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
    assign multi_hot = |(bus.gnt_oh_o & (bus.gnt_oh_o - {{(N-1){1'b0}}, 1'b1}));
    assign idx_oob   = 32'(bus.idx_o) >= 32'(N);

    assign bus.err_o = (bus.valid_o ^ (|bus.gnt_oh_o))
                     | multi_hot
                     | (bus.valid_o & ~gnt_at_idx)
                     | (bus.valid_o & idx_oob);
endmodule
